serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 118 +++++++++++
 tb/tb_serial_subtractor.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial 6-bit two's complement subtractor (d = a - b)
//
// Ports:
//   clk   in   1  rising-edge clock for all state
//   rst   in   1  synchronous active-high reset
//   start in   1  begin a subtraction; sampled only while idle
//   a     in   6  minuend, two's complement
//   b     in   6  subtrahend, two's complement
//   busy  out  1  high whenever the FSM is not idle
//   done  out  1  one-cycle pulse marking d and ovf valid
//   d     out  6  difference a - b, wraps modulo 64
//   ovf   out  1  signed overflow of the last completed subtraction

module serial_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [5:0] a,
  input  logic [5:0] b,
  output logic       busy,
  output logic       done,
  output logic [5:0] d,
  output logic       ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t     state;
  state_t     state_next;

  logic [5:0] a_r;
  logic [5:0] b_r;
  logic [2:0] cnt;
  logic       carry;

  logic [5:0] a_sh;
  logic [5:0] b_sh;
  logic       abit;
  logic       nbbit;
  logic       sum;
  logic       carry_next;
  logic       last_bit;

  // Shifting instead of indexing keeps the select in range once cnt
  // has stepped past bit 5 while sitting in DONE.
  always_comb begin
    a_sh       = a_r >> cnt;
    b_sh       = b_r >> cnt;
    abit       = a_sh[0];
    nbbit      = ~b_sh[0];
    // a - b is a + ~b + 1; the +1 enters as the initial carry.
    sum        = abit ^ nbbit ^ carry;
    carry_next = (abit & nbbit) | (abit & carry) | (nbbit & carry);
    last_bit   = (cnt == 3'd5);
  end

  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:    state_next = start ? SHIFT : IDLE;
      SHIFT:   state_next = last_bit ? DONE : SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_r   <= 6'd0;
      b_r   <= 6'd0;
      cnt   <= 3'd0;
      carry <= 1'b0;
      d     <= 6'd0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            cnt   <= 3'd0;
            carry <= 1'b1;
            d     <= 6'd0;
          end
        end
        SHIFT: begin
          // Bits arrive LSB first and enter at the MSB, so after six
          // shifts bit 0 has walked down to d[0].
          d     <= {sum, d[5:1]};
          carry <= carry_next;
          cnt   <= cnt + 3'd1;
          if (last_bit) begin
            // Operand signs differ and the result sign differs from a.
            ovf <= ~(abit ^ nbbit) & (sum ^ abit);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor

module tb_serial_subtractor;

  logic       clk;
  logic       rst;
  logic       start;
  logic [5:0] a;
  logic [5:0] b;
  logic       busy;
  logic       done;
  logic [5:0] d;
  logic       ovf;

  int n_checks;
  int n_fails;

  serial_subtractor dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .d    (d),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one operation from IDLE and follow it to completion.
  task automatic do_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                       input logic [5:0] exp_d, input logic exp_ovf, input bit scramble);
    int n;
    int busy_cycles;
    @(negedge clk);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    n           = 0;
    busy_cycles = 0;
    forever begin
      @(negedge clk);
      start = 1'b0;
      if (scramble) begin
        a = 6'd0;
        b = 6'd0;
      end
      if (busy) busy_cycles++;
      if (done || n > 20) break;
      @(posedge clk);
      n++;
    end
    check({tag, "_latency"}, 8'(n), 8'd6);
    check({tag, "_d"}, {2'b00, d}, {2'b00, exp_d});
    check({tag, "_ovf"}, {7'd0, ovf}, {7'd0, exp_ovf});
    check({tag, "_busy_cycles"}, 8'(busy_cycles), 8'd7);
    @(negedge clk);
    check({tag, "_idle_after"}, {6'd0, busy, done}, 8'd0);
    check({tag, "_d_hold"}, {2'b00, d}, {2'b00, exp_d});
  endtask

  initial begin
    int pulses;
    int seen;
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    start    = 1'b0;
    a        = 6'd0;
    b        = 6'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_state", {busy, done, d}, 8'd0);
    check("reset_ovf", {7'd0, ovf}, 8'd0);
    rst = 1'b0;

    do_op("5_minus_3", 6'b000101, 6'b000011, 6'b000010, 1'b0, 1'b0);
    do_op("3_minus_5", 6'b000011, 6'b000101, 6'b111110, 1'b0, 1'b0);
    do_op("0_minus_0", 6'b000000, 6'b000000, 6'b000000, 1'b0, 1'b0);
    do_op("m32_minus_1", 6'b100000, 6'b000001, 6'b011111, 1'b1, 1'b0);
    do_op("31_minus_m1", 6'b011111, 6'b111111, 6'b100000, 1'b1, 1'b0);
    do_op("10_minus_4_scrambled", 6'd10, 6'd4, 6'b000110, 1'b0, 1'b1);
    do_op("m32_minus_1_again", 6'b100000, 6'b000001, 6'b011111, 1'b1, 1'b0);

    // Abort on the third SHIFT edge; ovf is 1 from the previous op.
    @(negedge clk);
    a     = 6'd9;
    b     = 6'd2;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy_done", {6'd0, busy, done}, 8'd0);
    check("abort_d", {2'b00, d}, 8'd0);
    check("abort_ovf", {7'd0, ovf}, 8'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort_no_done", 8'(seen), 8'd0);
    do_op("after_abort", 6'd9, 6'd2, 6'b000111, 1'b0, 1'b0);

    // start coinciding with rst is discarded.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    a     = 6'd1;
    b     = 6'd1;
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("rst_start_discarded", {6'd0, busy, done}, 8'd0);
    repeat (2) @(negedge clk);
    check("rst_start_still_idle", {6'd0, busy, done}, 8'd0);

    // start held high: one operation every 8 edges.
    @(negedge clk);
    a      = 6'b111000;
    b      = 6'b000111;
    start  = 1'b1;
    pulses = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 23) start = 1'b0;
      if (done) begin
        check("b2b_pulse_position", 8'(i), 8'(6 + 8 * pulses));
        check("b2b_d", {2'b00, d}, {2'b00, 6'b110001});
        check("b2b_ovf", {7'd0, ovf}, 8'd0);
        pulses++;
      end
    end
    check("b2b_pulse_count", 8'(pulses), 8'd3);
    @(negedge clk);
    check("b2b_idle_after", {6'd0, busy, done}, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
